// File: rtl/dft8_frame_ctrl.sv
// dft8_frame_ctrl
// Frame sequencer for one 8-point radix-2 butterfly stage.
// Collects eight packed complex samples from a serial source and presents
// them in parallel to the butterfly datapath. After the configured datapath
// latency it captures the eight results and streams them back out serially,
// marking the last one.
//
// Parameters
//   DP_LAT    datapath latency in cycles (0..3, 0 = combinational datapath)
//   FCW       width of the completed-frame counter
// Ports
//   clk       rising-edge clock
//   rst_n     synchronous reset, active low
//   s_valid   input sample valid
//   s_ready   input sample accepted this cycle (FILL phase)
//   s_data    packed sample {re[3:0], im[3:0]}
//   dp_in     frame to the datapath, slot k at [8k+7:8k]
//   dp_out    datapath results, same packing as dp_in
//   m_valid   output sample valid (DRAIN phase)
//   m_ready   downstream accepts the output sample
//   m_data    result sample, packed like s_data
//   m_last    marks result slot 7
//   busy      frame partially filled, computing or draining
//   frame_cnt completed frames, wraps modulo 2^FCW
module dft8_frame_ctrl #(
    parameter int DP_LAT = 0,
    parameter int FCW    = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           s_valid,
    output logic           s_ready,
    input  logic [7:0]     s_data,
    output logic [63:0]    dp_in,
    input  logic [63:0]    dp_out,
    output logic           m_valid,
    input  logic           m_ready,
    output logic [7:0]     m_data,
    output logic           m_last,
    output logic           busy,
    output logic [FCW-1:0] frame_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILL    = 2'd1,
        COMPUTE = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    localparam logic [1:0] LAT_LAST = 2'(DP_LAT);

    state_t         state_reg, state_next;
    logic [2:0]     idx_reg, idx_next;
    logic [1:0]     lat_reg, lat_next;
    logic [7:0]     in_buf_reg  [8];
    logic [7:0]     res_buf_reg [8];
    logic [FCW-1:0] frame_cnt_reg;

    logic in_wr;      // write s_data into input slot idx_reg
    logic capture;    // latch the whole dp_out word into the result buffer
    logic inc_frame;  // last result handed off

    // State, slot index and latency counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            idx_reg   <= 3'd0;
            lat_reg   <= 2'd0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            lat_reg   <= lat_next;
        end
    end

    // Next state and handshake outputs. Every output here depends only on
    // registered state; s_valid / m_ready only steer the next-state terms.
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        lat_next   = lat_reg;
        s_ready    = 1'b0;
        m_valid    = 1'b0;
        m_last     = 1'b0;
        m_data     = 8'd0;
        in_wr      = 1'b0;
        capture    = 1'b0;
        inc_frame  = 1'b0;
        case (state_reg)
            IDLE: begin
                state_next = FILL;
            end
            FILL: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    in_wr    = 1'b1;
                    idx_next = idx_reg + 3'd1;  // 7 wraps to 0 for DRAIN
                    if (idx_reg == 3'd7) begin
                        state_next = COMPUTE;
                    end
                end
            end
            COMPUTE: begin
                if (lat_reg == LAT_LAST) begin
                    capture    = 1'b1;
                    lat_next   = 2'd0;
                    state_next = DRAIN;
                end else begin
                    lat_next = lat_reg + 2'd1;
                end
            end
            DRAIN: begin
                m_valid = 1'b1;
                m_data  = res_buf_reg[idx_reg];
                m_last  = (idx_reg == 3'd7);
                if (m_ready) begin
                    idx_next = idx_reg + 3'd1;
                    if (idx_reg == 3'd7) begin
                        inc_frame  = 1'b1;
                        state_next = FILL;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy = (state_reg == COMPUTE) || (state_reg == DRAIN) ||
                  ((state_reg == FILL) && (idx_reg != 3'd0));

    // Sample buffers. The input buffer is deliberately not cleared between
    // frames so dp_in keeps showing the previous frame outside COMPUTE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 8; k++) begin
                in_buf_reg[k]  <= 8'd0;
                res_buf_reg[k] <= 8'd0;
            end
        end else begin
            if (in_wr) begin
                in_buf_reg[idx_reg] <= s_data;
            end
            if (capture) begin
                for (int k = 0; k < 8; k++) begin
                    res_buf_reg[k] <= dp_out[8*k +: 8];
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_dp_slot
            assign dp_in[8*gi +: 8] = in_buf_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt_reg <= '0;
        end else if (inc_frame) begin
            frame_cnt_reg <= frame_cnt_reg + FCW'(1);
        end
    end

    assign frame_cnt = frame_cnt_reg;

endmodule

// File: tb/tb_dft8_frame_ctrl.sv
// Testbench for dft8_frame_ctrl.
// Two instances share one stimulus stream: u0 (DP_LAT=0, FCW=2, datapath
// stub ~dp_in combinational) and u1 (DP_LAT=3, FCW=8, stub ~dp_in through
// three registers). A behavioural model per instance, phrased as "samples
// collected / compute cycles left / results still owed", predicts every
// output each cycle. A short directed frame pins the model with literals.
module tb_dft8_frame_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_valid;
    logic        m_ready;
    logic [7:0]  s_data;
    logic [1:0]  s_ready;
    logic [1:0]  m_valid;
    logic [1:0]  m_last;
    logic [1:0]  busy;
    logic [7:0]  m_data [2];
    logic [63:0] dp_in  [2];
    logic [63:0] dp_out [2];
    logic [1:0]  fc0;
    logic [7:0]  fc1;
    logic [63:0] r1, r2, r3;

    always #5 clk = ~clk;

    dft8_frame_ctrl #(.DP_LAT(0), .FCW(2)) u0 (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready[0]),
        .s_data(s_data), .dp_in(dp_in[0]), .dp_out(dp_out[0]),
        .m_valid(m_valid[0]), .m_ready(m_ready), .m_data(m_data[0]),
        .m_last(m_last[0]), .busy(busy[0]), .frame_cnt(fc0)
    );

    dft8_frame_ctrl #(.DP_LAT(3), .FCW(8)) u1 (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready[1]),
        .s_data(s_data), .dp_in(dp_in[1]), .dp_out(dp_out[1]),
        .m_valid(m_valid[1]), .m_ready(m_ready), .m_data(m_data[1]),
        .m_last(m_last[1]), .busy(busy[1]), .frame_cnt(fc1)
    );

    // Datapath stubs: bitwise inversion, zero and three cycles deep.
    assign dp_out[0] = ~dp_in[0];
    always @(posedge clk) begin
        r1 <= ~dp_in[1];
        r2 <= r1;
        r3 <= r2;
    end
    assign dp_out[1] = r3;

    int n_cmp = 0;
    int n_err = 0;
    bit check_on = 1'b0;

    // Model state per instance.
    bit          started  [2];
    int          nin      [2];
    int          cmp_left [2];
    int          rem      [2];
    int          fcnt     [2];
    logic [63:0] img      [2];
    logic [7:0]  samp     [2][8];
    logic [7:0]  res      [2][8];
    int          lat_cfg  [2] = '{0, 3};
    int          fc_mod   [2] = '{4, 256};

    task automatic chk(input string nm, input int inst,
                       input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s u%0d: got %h, expected %h (t=%0t)", nm, inst, act, exp, $time);
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                started[i] = 1'b0; nin[i] = 0; cmp_left[i] = 0; rem[i] = 0;
                fcnt[i] = 0; img[i] = '0;
            end else if (!started[i]) begin
                started[i] = 1'b1;              // the single idle cycle
            end else if (rem[i] > 0) begin
                if (m_ready) begin
                    rem[i]--;
                    if (rem[i] == 0) fcnt[i]++;
                end
            end else if (cmp_left[i] > 0) begin
                cmp_left[i]--;
                if (cmp_left[i] == 0) begin
                    for (int k = 0; k < 8; k++) res[i][k] = ~samp[i][k];
                    rem[i] = 8;
                end
            end else if (s_valid) begin
                img[i][8*nin[i] +: 8] = s_data;
                samp[i][nin[i]] = s_data;
                nin[i]++;
                if (nin[i] == 8) begin
                    nin[i] = 0;
                    cmp_left[i] = lat_cfg[i] + 1;
                end
            end
        end
    endtask

    task automatic compare_all();
        logic [63:0] fc_act;
        logic [7:0]  exp_data;
        for (int i = 0; i < 2; i++) begin
            fc_act   = (i == 0) ? 64'(fc0) : 64'(fc1);
            exp_data = (rem[i] > 0) ? res[i][8 - rem[i]] : 8'd0;
            chk("s_ready", i, s_ready[i], (started[i] && rem[i] == 0 && cmp_left[i] == 0));
            chk("m_valid", i, m_valid[i], (rem[i] > 0));
            chk("m_data",  i, m_data[i], exp_data);
            chk("m_last",  i, m_last[i], (rem[i] == 1));
            chk("busy",    i, busy[i], (nin[i] > 0 || cmp_left[i] > 0 || rem[i] > 0));
            chk("dp_in",   i, dp_in[i], img[i]);
            chk("frame_cnt", i, fc_act, 64'(fcnt[i] % fc_mod[i]));
            chk("excl",    i, (s_ready[i] & m_valid[i]), 0);
        end
    endtask

    initial begin
        int n;
        int guard;
        int bp_left;
        rst_n = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_data = 8'd0;
        fork
            forever begin @(posedge clk); model_step(); end
            forever begin @(negedge clk); if (check_on) compare_all(); end
        join_none

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_s_ready", 0, s_ready[0], 0);
        chk("rst_m_valid", 0, m_valid[0], 0);
        chk("rst_busy",    0, busy[0], 0);
        chk("rst_dp_in",   0, dp_in[0], 0);
        chk("rst_m_data",  0, m_data[0], 0);
        chk("rst_frame_cnt", 0, fc0, 0);
        check_on = 1'b1;

        // Directed frame 0x01..0x08, back-to-back, no backpressure.
        @(posedge clk); #2;
        rst_n = 1'b1; s_valid = 1'b1; s_data = 8'h01; m_ready = 1'b1;
        @(negedge clk); chk("idle_s_ready", 0, s_ready[0], 0);
        @(negedge clk); chk("fill_s_ready", 0, s_ready[0], 1);
        n = 0; guard = 0;
        while (n < 8 && guard < 40) begin
            @(posedge clk);
            if (s_ready[0]) n++;
            #2 s_data = 8'h01 + 8'(n);
            guard++;
        end
        chk("fill_transfers", 0, n, 8);
        s_valid = 1'b0;
        @(negedge clk);
        chk("compute_dp_in",   0, dp_in[0], 64'h0807060504030201);
        chk("compute_m_valid", 0, m_valid[0], 0);
        chk("compute_busy",    0, busy[0], 1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("drain_m_valid", 0, m_valid[0], 1);
            chk("drain_m_data",  0, m_data[0], 8'hFE - 8'(k));
            chk("drain_m_last",  0, m_last[0], (k == 7));
            if (k == 2) chk("lat3_still_compute", 1, m_valid[1], 0);
            if (k == 3) begin
                chk("lat3_first_valid", 1, m_valid[1], 1);
                chk("lat3_first_data",  1, m_data[1], 8'hFE);
            end
        end
        @(negedge clk);
        chk("refill_s_ready", 0, s_ready[0], 1);
        chk("frame_cnt_one",  0, fc0, 1);

        // Randomised traffic with gaps, backpressure bursts and occasional resets.
        bp_left = 0;
        for (int c = 0; c < 6000; c++) begin
            @(posedge clk); #2;
            rst_n   = ($urandom_range(0, 299) != 0);
            s_valid = ($urandom_range(0, 2) != 0);
            s_data  = 8'($urandom);
            if (bp_left > 0) begin
                m_ready = 1'b0;
                bp_left--;
            end else if ($urandom_range(0, 39) == 0) begin
                m_ready = 1'b0;
                bp_left = 5;
            end else begin
                m_ready = ($urandom_range(0, 3) != 0);
            end
        end
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dft8_frame_ctrl.md
# dft8_frame_ctrl

Frame sequencer for the 8-point radix-2 butterfly stage (`DFT8`). It accepts packed complex samples one per handshake and assembles them into an 8-sample frame. It presents the frame in parallel to the butterfly datapath, waits a configurable datapath latency, and captures the 8 results. It then streams the results out one per handshake with an end-of-frame marker. It sits between the serial sample source and each butterfly stage of the pipelined FFT.

## Interface

- `DP_LAT`, default 0: datapath latency in cycles from `dp_in` stable to `dp_out` valid. Legal range is 0..3; 0 means combinational.
- `FCW`, default 8: width of the frame counter.
- `clk` input 1: single clock; all logic is rising-edge.
- `rst_n` input 1: synchronous reset, active-low.
- `s_valid` input 1: input sample valid.
- `s_ready` output 1: controller accepts a sample; a transfer happens on a rising edge with `s_valid && s_ready`.
- `s_data` input 8: packed sample, real part in [7:4] and imaginary part in [3:0], both 4-bit two's complement.
- `dp_in` output 64: frame to the datapath; slot k (0..7) occupies bits [8k+7:8k] and maps to butterfly input k+1.
- `dp_out` input 64: datapath results; slot k maps to butterfly output k+1, using the same packing.
- `m_valid` output 1: output sample valid.
- `m_ready` input 1: downstream accepts the output sample.
- `m_data` output 8: result sample, packed like `s_data`.
- `m_last` output 1: high with `m_valid` on result slot 7.
- `busy` output 1: a frame is partially filled, computing or draining.
- `frame_cnt` output FCW: count of completed frames; wraps modulo 2^FCW.

## Operation

- The state machine has four states: IDLE, FILL, COMPUTE, DRAIN. A 3-bit slot index `idx` and a 2-bit latency counter `lat` support it.
- Reset (`rst_n` low at an edge) sets:
  - state = IDLE, `idx` = 0, `lat` = 0;
  - input buffer and result buffer = 0;
  - `frame_cnt` = 0;
  - all outputs 0.
- IDLE: `s_ready`=0. Moves unconditionally to FILL on the next cycle.
- FILL: `s_ready`=1.
  - Each transfer writes `s_data` into input slot `idx` and increments `idx`.
  - The transfer at `idx`=7 sets `idx` to 0 and moves to COMPUTE.
  - If `s_valid` is low, state and `idx` hold.
- COMPUTE: `s_ready`=0 and `dp_in` is held stable.
  - `lat` counts 0..`DP_LAT`.
  - On the edge where `lat`==`DP_LAT`, the controller captures all of `dp_out` into the result buffer, clears `lat` and moves to DRAIN.
- DRAIN: `m_valid`=1, `m_data` = result slot `idx`, `m_last` = (`idx`==7).
  - Each `m_valid && m_ready` increments `idx`.
  - The handshake at `idx`=7 increments `frame_cnt`, sets `idx` to 0 and moves to FILL.
  - If `m_ready` is low, `m_data` and `idx` hold.
- `dp_in` is driven directly from the input buffer register. It keeps the last frame's contents outside COMPUTE; it is never cleared except by reset.
- `busy` = (state==COMPUTE) || (state==DRAIN) || (state==FILL && `idx`!=0).
- The controller does no arithmetic on sample data. Widths pass through unchanged and samples are never sign-extended or saturated.
- Input and output phases never overlap: `s_ready` and `m_valid` are never high in the same cycle.

## Timing

- `s_ready`, `m_valid`, `m_last`, `m_data` and `busy` are decoded from registered state only. None of them has a combinational path from `s_valid` or `m_ready`.
- After `rst_n` rises: one IDLE cycle, then `s_ready`=1 from the second cycle.
- Edge after the 8th input transfer: COMPUTE begins and `dp_in` shows the complete frame.
- COMPUTE lasts exactly `DP_LAT`+1 cycles, and `dp_out` is sampled at the final edge of COMPUTE. The datapath must present a valid `dp_out` within that window.
- `m_valid` rises on the cycle after capture.
- Minimum frame period with `s_valid` and `m_ready` held high is 8 + (`DP_LAT`+1) + 8 cycles; this is 17 cycles at `DP_LAT`=0.
- Backpressure: `m_ready` low for N cycles extends DRAIN by N cycles with no data loss or duplication.
- Reset mid-operation (any state, any `idx`) aborts the frame. Nothing is output, `frame_cnt` is unchanged from its reset value of 0, and the controller restarts at IDLE.
- `frame_cnt` wraps from 2^FCW−1 to 0 on the next completed frame.

## Test plan

- **Basic frame, `DP_LAT`=0.** Stub sets `dp_out` = ~`dp_in`. Feed 0x01..0x08 back-to-back -> `dp_in`=0x0807060504030201 during COMPUTE; outputs are 0xFE,0xFD,...,0xF7, `m_last` only on 0xF7; `frame_cnt`=1; total 17 cycles.
- **Latency `DP_LAT`=3.** Stub delays ~`dp_in` by 3 registers. Same stimulus -> COMPUTE lasts 4 cycles, same outputs, first `m_valid` 4 cycles after the 8th transfer.
- **Gaps and backpressure.** `s_valid` toggles 1,0,1,0... and `m_ready` is low for 5 cycles at `idx`=3. Expect identical output sequence; 0xFB is held stable for 5 extra cycles and is not repeated.
- **Mid-frame reset.** Reset during FILL at `idx`=5, then during DRAIN at `idx`=2. Expect all outputs 0 at the reset edge and `s_ready`=0 for the IDLE cycle after release; the next full frame of 0x10..0x17 yields 0xEF..0xE8 with `frame_cnt`=1.
- **Wrap with `FCW`=2.** Run 5 consecutive frames -> `frame_cnt` reads 1,2,3,0,1; `s_ready` and `m_valid` are never high together.
